// File: rtl/lc3_pkg.sv
// Shared LC-3 decode definitions: opcodes, decode FSM states, CC reset value.
// LC3_HALT_DETECT_EN adds the sticky S_HALT state for TRAP x25.
package lc3_pkg;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [2:0]  CC_RESET  = 3'b010;
  localparam logic [15:0] TRAP_HALT = 16'hF025;

`ifdef LC3_HALT_DETECT_EN
  typedef enum logic [2:0] {S_WAIT_MEM, S_ISSUE, S_EXEC, S_START, S_HALT} state_t;
`else
  typedef enum logic [2:0] {S_WAIT_MEM, S_ISSUE, S_EXEC, S_START} state_t;
`endif

  // Only instructions that write a register update the condition codes.
  function automatic logic sets_cc(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) || (op == OP_LD) ||
           (op == OP_LDI) || (op == OP_LDR) || (op == OP_LEA);
  endfunction

endpackage

// File: rtl/decode_fields.sv
// Combinational IR-to-field slicing for LC-3 plus the sets-CC flag.
module decode_fields
  import lc3_pkg::*;
(
  input  logic [15:0] i_ir,
  output logic [3:0]  o_opcode,
  output logic [8:0]  o_offset,
  output logic [2:0]  o_br_nzp,
  output logic [2:0]  o_dr,
  output logic [2:0]  o_sr1,
  output logic [2:0]  o_sr2,
  output logic [4:0]  o_imm5,
  output logic        o_imm_sel,
  output logic        o_sets_cc
);

  always_comb begin
    o_opcode  = i_ir[15:12];
    o_offset  = i_ir[8:0];
    o_br_nzp  = i_ir[11:9];
    o_dr      = i_ir[11:9];
    o_sr1     = i_ir[8:6];
    o_sr2     = i_ir[2:0];
    o_imm5    = i_ir[4:0];
    o_imm_sel = i_ir[5];
    o_sets_cc = sets_cc(i_ir[15:12]);
  end

endmodule

// File: rtl/decode.sv
// LC-3 decode stage: waits out memory latency, captures IR, issues to execute,
// maintains NZP and pulses fetch_start. LC3_HALT_DETECT_EN enables TRAP HALT stop.
module decode
  import lc3_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned CNT_W       = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mem_dout,
  output logic        fetch_start,
  output logic [3:0]  opCode_out,
  output logic [8:0]  offset_out,
  output logic [2:0]  br_nzp_out,
  output logic [2:0]  result_nzp_out,
  output logic [2:0]  dr_out,
  output logic [2:0]  sr1_out,
  output logic [2:0]  sr2_out,
  output logic [4:0]  imm5_out,
  output logic        imm_sel_out,
  output logic [15:0] ir_out,
  output logic        dec_valid,
  input  logic        exec_ready,
  input  logic        exec_done,
  input  logic [2:0]  exec_nzp,
  output logic        halted
);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [15:0]      r_ir;
  logic [2:0]       r_cc, w_cc_next;
  logic             w_capture;
  logic             w_sets_cc;

  decode_fields u_fields (
    .i_ir      (r_ir),
    .o_opcode  (opCode_out),
    .o_offset  (offset_out),
    .o_br_nzp  (br_nzp_out),
    .o_dr      (dr_out),
    .o_sr1     (sr1_out),
    .o_sr2     (sr2_out),
    .o_imm5    (imm5_out),
    .o_imm_sel (imm_sel_out),
    .o_sets_cc (w_sets_cc)
  );

  assign ir_out         = r_ir;
  assign result_nzp_out = r_cc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_WAIT_MEM;
      r_cnt   <= '0;
      r_ir    <= '0;
      r_cc    <= CC_RESET;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_cc    <= w_cc_next;
      if (w_capture) r_ir <= mem_dout;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_cnt_next  = r_cnt;
    w_cc_next   = r_cc;
    w_capture   = 1'b0;
    fetch_start = 1'b0;
    dec_valid   = 1'b0;
    halted      = 1'b0;
    case (r_state)
      S_WAIT_MEM: begin
        if (r_cnt == CNT_W'(MEM_LATENCY)) begin
          w_capture  = 1'b1;
          w_cnt_next = '0;
          w_next     = S_ISSUE;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_ISSUE: begin
`ifdef LC3_HALT_DETECT_EN
        if (r_ir == TRAP_HALT) begin
          w_next = S_HALT;
        end else begin
          dec_valid = 1'b1;
          if (exec_ready) w_next = S_EXEC;
        end
`else
        dec_valid = 1'b1;
        if (exec_ready) w_next = S_EXEC;
`endif
      end
      S_EXEC: begin
        if (exec_done) begin
          if (w_sets_cc) w_cc_next = exec_nzp;
          w_next = S_START;
        end
      end
      S_START: begin
        fetch_start = 1'b1;
        w_cnt_next  = '0;
        w_next      = S_WAIT_MEM;
      end
`ifdef LC3_HALT_DETECT_EN
      S_HALT: begin
        halted = 1'b1;
      end
`endif
      default: w_next = S_WAIT_MEM;
    endcase
  end

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: per-cycle compare against a protocol-level model
// plus hand-computed literal checks.
module tb_decode;

  localparam int unsigned ML = 1;
`ifdef LC3_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mem_dout = 16'h0000;
  logic        exec_ready = 1'b0;
  logic        exec_done = 1'b0;
  logic [2:0]  exec_nzp = 3'b000;
  logic        fetch_start, dec_valid, halted, imm_sel_out;
  logic [3:0]  opCode_out;
  logic [8:0]  offset_out;
  logic [2:0]  br_nzp_out, result_nzp_out, dr_out, sr1_out, sr2_out;
  logic [4:0]  imm5_out;
  logic [15:0] ir_out;

  int n_cmp = 0;
  int n_bad = 0;

  decode #(.MEM_LATENCY(ML), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .mem_dout(mem_dout), .fetch_start(fetch_start),
    .opCode_out(opCode_out), .offset_out(offset_out), .br_nzp_out(br_nzp_out),
    .result_nzp_out(result_nzp_out), .dr_out(dr_out), .sr1_out(sr1_out),
    .sr2_out(sr2_out), .imm5_out(imm5_out), .imm_sel_out(imm_sel_out),
    .ir_out(ir_out), .dec_valid(dec_valid), .exec_ready(exec_ready),
    .exec_done(exec_done), .exec_nzp(exec_nzp), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Protocol model: where the instruction is in its life, not how the RTL counts.
  localparam int PH_WAIT = 0, PH_ISSUE = 1, PH_EXEC = 2, PH_START = 3, PH_HALT = 4;
  int          m_phase = PH_WAIT;
  int          m_left = ML + 1;
  logic [15:0] m_ir = 16'h0;
  logic [2:0]  m_cc = 3'b010;
  bit          started = 1'b0;

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      m_phase = PH_WAIT; m_left = ML + 1; m_ir = 16'h0; m_cc = 3'b010;
    end else if (m_phase == PH_WAIT) begin
      m_left = m_left - 1;
      if (m_left == 0) begin m_ir = mem_dout; m_phase = PH_ISSUE; end
    end else if (m_phase == PH_ISSUE) begin
      if (HALT_EN && m_ir == 16'hF025) m_phase = PH_HALT;
      else if (exec_ready) m_phase = PH_EXEC;
    end else if (m_phase == PH_EXEC) begin
      if (exec_done) begin
        if (m_ir[15:12] inside {4'h1, 4'h5, 4'h9, 4'h2, 4'hA, 4'h6, 4'hE}) m_cc = exec_nzp;
        m_phase = PH_START;
      end
    end else if (m_phase == PH_START) begin
      m_phase = PH_WAIT; m_left = ML + 1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_fetch_start", 16'(fetch_start), 16'(m_phase == PH_START));
      chk("m_dec_valid", 16'(dec_valid),
          16'(m_phase == PH_ISSUE && !(HALT_EN && m_ir == 16'hF025)));
      chk("m_halted", 16'(halted), 16'(m_phase == PH_HALT));
      chk("m_ir", ir_out, m_ir);
      chk("m_cc", 16'(result_nzp_out), 16'(m_cc));
      chk("m_opcode", 16'(opCode_out), 16'(m_ir[15:12]));
      chk("m_offset", 16'(offset_out), 16'(m_ir[8:0]));
      chk("m_br_nzp", 16'(br_nzp_out), 16'(m_ir[11:9]));
      chk("m_dr", 16'(dr_out), 16'(m_ir[11:9]));
      chk("m_sr1", 16'(sr1_out), 16'(m_ir[8:6]));
      chk("m_sr2", 16'(sr2_out), 16'(m_ir[2:0]));
      chk("m_imm5", 16'(imm5_out), 16'(m_ir[4:0]));
      chk("m_imm_sel", 16'(imm_sel_out), 16'(m_ir[5]));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_fetch_start"}, 16'(fetch_start), 16'h0);
    chk({tag, "_dec_valid"}, 16'(dec_valid), 16'h0);
    chk({tag, "_ir"}, ir_out, 16'h0000);
    chk({tag, "_cc"}, 16'(result_nzp_out), 16'h2);
  endtask

  int fs_count;

  initial begin
    mem_dout = 16'h1261; exec_ready = 1'b1;
    step(2);
    chk_reset_vals("rst0");
    rst = 1'b0;
    step(1);
    chk("lat_no_capture_yet", ir_out, 16'h0000);
    step(1);
    // ADD R1,R1,#1 captured on the second edge after release
    chk("add_ir", ir_out, 16'h1261);
    chk("add_op", 16'(opCode_out), 16'h1);
    chk("add_dr", 16'(dr_out), 16'h1);
    chk("add_sr1", 16'(sr1_out), 16'h1);
    chk("add_imm_sel", 16'(imm_sel_out), 16'h1);
    chk("add_imm5", 16'(imm5_out), 16'h01);
    chk("add_dec_valid", 16'(dec_valid), 16'h1);
    chk("add_no_fetch", 16'(fetch_start), 16'h0);
    step(1);
    chk("add_valid_drop", 16'(dec_valid), 16'h0);
    mem_dout = 16'h0403; exec_done = 1'b1; exec_nzp = 3'b100;
    step(1);
    exec_done = 1'b0;
    chk("add_cc", 16'(result_nzp_out), 16'h4);
    chk("add_fetch_pulse", 16'(fetch_start), 16'h1);
    step(1);
    chk("add_fetch_once", 16'(fetch_start), 16'h0);
    step(2);
    chk("br_ir", ir_out, 16'h0403);
    step(1);
    exec_done = 1'b1; exec_nzp = 3'b010;
    step(1);
    exec_done = 1'b0;
    chk("br_fetch_pulse", 16'(fetch_start), 16'h1);
    chk("br_nzp", 16'(br_nzp_out), 16'h2);
    chk("br_offset", 16'(offset_out), 16'h003);
    chk("br_cc_kept", 16'(result_nzp_out), 16'h4);
    mem_dout = 16'h5020; exec_ready = 1'b0;
    step(3);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 16'(dec_valid), 16'h1);
      chk("stall_ir", ir_out, 16'h5020);
      chk("stall_no_fetch", 16'(fetch_start), 16'h0);
      exec_done = (i == 1); exec_nzp = 3'b001;
      step(1);
    end
    exec_done = 1'b0;
    chk("stall_done_ignored", 16'(result_nzp_out), 16'h4);
    exec_ready = 1'b1;
    step(1);
    rst = 1'b1;
    step(1);
    chk_reset_vals("rst_exec");
    rst = 1'b0; mem_dout = 16'h1261;
    step(3);
    exec_done = 1'b1; exec_nzp = 3'b001;
    step(1);
    exec_done = 1'b0;
    chk("pre_rst_pulse", 16'(fetch_start), 16'h1);
    chk("pre_rst_cc", 16'(result_nzp_out), 16'h1);
    rst = 1'b1;
    step(1);
    chk_reset_vals("rst_start");
    rst = 1'b0; mem_dout = 16'h927F;
    step(2);
    chk("not_sr1", 16'(sr1_out), 16'h1);
    chk("not_imm5", 16'(imm5_out), 16'h1F);
    step(1);
    exec_done = 1'b1; exec_nzp = 3'b100;
    step(1);
    exec_done = 1'b0;
    chk("not_cc", 16'(result_nzp_out), 16'h4);
    mem_dout = 16'hF025;
    step(3);
    chk("trap_ir", ir_out, 16'hF025);
    if (HALT_EN) begin
      chk("trap_no_valid", 16'(dec_valid), 16'h0);
      fs_count = 0;
      for (int i = 0; i < 20; i++) begin
        step(1);
        fs_count += int'(fetch_start);
        chk("halt_flag", 16'(halted), 16'h1);
        chk("halt_no_valid", 16'(dec_valid), 16'h0);
      end
      chk("halt_fetch_count", 16'(fs_count), 16'h0);
    end else begin
      chk("trap_valid", 16'(dec_valid), 16'h1);
      chk("trap_not_halted", 16'(halted), 16'h0);
      step(1);
      exec_done = 1'b1; exec_nzp = 3'b001;
      step(1);
      exec_done = 1'b0;
      chk("trap_fetch", 16'(fetch_start), 16'h1);
      chk("trap_cc_kept", 16'(result_nzp_out), 16'h4);
      step(4);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
